// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: line-state encodings, frame constants and baud divisor helper.
package uart_tx_pkg;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam int unsigned UART_FRAME_BITS = 10;
    localparam int unsigned UART_BIT_IDX_W  = 3;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

    // Integer-truncated number of clk cycles per line bit.
    function automatic int unsigned clks_per_bit(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: pulses tick in the last cycle of every CLKS_PER_BIT-cycle period.
module uart_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 217
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (restart || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with valid/ready input and a one-entry holding register.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 25_000_000,
    parameter int unsigned BAUD_RATE   = 115200
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tx_valid,
    input  logic [UART_DATA_BITS-1:0] tx_data,
    output logic                      tx_ready,
    output logic                      tx_busy,
    output logic                      txd
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);

    if (CLKS_PER_BIT < 2) begin : g_cpb_check
        $error("uart_tx: CLK_FREQ_HZ / BAUD_RATE must be at least 2");
    end

    uart_state_e                 state_q, state_d;
    logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
    logic [UART_DATA_BITS-1:0]   hold_q, hold_d;
    logic                        hold_full_q, hold_full_d;
    logic [UART_BIT_IDX_W-1:0]   bit_q, bit_d;
    logic                        txd_q, txd_d;

    logic tick;
    logic accept;
    logic last_stop;
    logic shifter_free;
    logic bypass;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk    (clk),
        .rst    (rst),
        .restart(state_q == UART_IDLE),
        .tick   (tick)
    );

    assign tx_ready     = !hold_full_q;
    assign tx_busy      = (state_q != UART_IDLE) || hold_full_q;
    assign txd          = txd_q;
    assign accept       = tx_valid && tx_ready;
    assign last_stop    = (state_q == UART_STOP) && tick;
    assign shifter_free = (state_q == UART_IDLE) || last_stop;
    assign bypass       = accept && shifter_free;

    // Next-state, shifter and holding-register update; txd follows the next state.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        bit_d       = bit_q;
        txd_d       = 1'b1;

        if (accept && !shifter_free) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end

        case (state_q)
            UART_IDLE: begin
                if (bypass) begin
                    state_d = UART_START;
                    shift_d = tx_data;
                end
            end
            UART_START: begin
                if (tick) begin
                    state_d = UART_DATA;
                    bit_d   = '0;
                end
            end
            UART_DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == UART_BIT_IDX_W'(UART_DATA_BITS - 1)) begin
                        state_d = UART_STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + UART_BIT_IDX_W'(1);
                    end
                end
            end
            UART_STOP: begin
                if (tick) begin
                    if (hold_full_q) begin
                        state_d     = UART_START;
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                    end else if (bypass) begin
                        state_d = UART_START;
                        shift_d = tx_data;
                    end else begin
                        state_d = UART_IDLE;
                    end
                end
            end
            default: begin
                state_d = UART_IDLE;
            end
        endcase

        case (state_d)
            UART_START: txd_d = 1'b0;
            UART_DATA:  txd_d = shift_d[0];
            default:    txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= UART_IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            bit_q       <= '0;
            txd_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            bit_q       <= bit_d;
            txd_q       <= txd_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame-offset model, per-cycle compare, loopback receiver.
module tb_uart_tx;

    localparam int unsigned CLK_HZ = 1_000_000;
    localparam int unsigned BAUD   = 250_000;
    localparam int CPB       = 4;
    localparam int FRAME_CYC = 10 * CPB;
    localparam int LOG_N     = 20000;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_ready;
    logic       tx_busy;
    logic       txd;

    uart_tx #(
        .CLK_FREQ_HZ(CLK_HZ),
        .BAUD_RATE  (BAUD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tx_valid(tx_valid),
        .tx_data (tx_data),
        .tx_ready(tx_ready),
        .tx_busy (tx_busy),
        .txd     (txd)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a frame is just a start time offset; bytes wait in a one-deep pending slot.
    int         ecnt     = 0;
    bit         m_ok     = 1'b0;
    bit         m_active = 1'b0;
    bit         m_pend   = 1'b0;
    int         m_off    = 0;
    logic [7:0] m_byte   = 8'h00;
    logic [7:0] m_pbyte  = 8'h00;

    function automatic logic model_txd();
        int slot;
        if (!m_active) return 1'b1;
        slot = m_off / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return m_byte[slot-1];
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        bit acc;
        bit took;
        ecnt++;
        if (rst) begin
            m_ok     = 1'b1;
            m_active = 1'b0;
            m_pend   = 1'b0;
        end else if (m_ok) begin
            acc  = tx_valid && !m_pend;
            took = 1'b0;
            if (m_active) begin
                if (m_off == FRAME_CYC - 1) begin
                    if (m_pend) begin
                        m_byte = m_pbyte;
                        m_off  = 0;
                        m_pend = 1'b0;
                    end else if (acc) begin
                        m_byte = tx_data;
                        m_off  = 0;
                        took   = 1'b1;
                    end else begin
                        m_active = 1'b0;
                    end
                end else begin
                    m_off++;
                end
            end else if (acc) begin
                m_active = 1'b1;
                m_off    = 0;
                m_byte   = tx_data;
                took     = 1'b1;
            end
            if (acc && !took) begin
                m_pend  = 1'b1;
                m_pbyte = tx_data;
            end
        end
    end

    logic txd_log [LOG_N];
    logic rdy_log [LOG_N];
    logic busy_log[LOG_N];

    bit         r_busy = 1'b0;
    int         r_cnt  = 0;
    logic [7:0] r_sh   = 8'h00;
    logic [7:0] rx_q[$];

    // Per-cycle compare against the model, trace logging and a mid-bit sampling receiver.
    always @(negedge clk) begin
        int slot;
        if (ecnt < LOG_N) begin
            txd_log[ecnt]  = txd;
            rdy_log[ecnt]  = tx_ready;
            busy_log[ecnt] = tx_busy;
        end
        if (m_ok) begin
            check("txd", 32'(txd), 32'(model_txd()));
            check("tx_ready", 32'(tx_ready), 32'(!m_pend));
            check("tx_busy", 32'(tx_busy), 32'(m_active || m_pend));
        end
        if (rst) begin
            r_busy = 1'b0;
        end else if (m_ok) begin
            if (!r_busy) begin
                if (txd === 1'b0) begin
                    r_busy = 1'b1;
                    r_cnt  = 0;
                end
            end else begin
                r_cnt++;
            end
            if (r_busy && (r_cnt % CPB) == CPB / 2) begin
                slot = r_cnt / CPB;
                if (slot == 0) begin
                    check("rx_start_bit", 32'(txd), 32'(0));
                end else if (slot <= 8) begin
                    r_sh[slot-1] = txd;
                end else begin
                    check("rx_stop_bit", 32'(txd), 32'(1));
                    rx_q.push_back(r_sh);
                    r_busy = 1'b0;
                end
            end
        end
    end

    // Called in the low phase; returns at the negedge after the accepting edge.
    // s is the trace index of the cycle right after the accepting edge.
    task automatic send(input logic [7:0] b, output int s);
        int n;
        n        = 0;
        tx_valid = 1'b1;
        tx_data  = b;
        while (tx_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("send_ready_wait", 32'(n < 200), 32'(1));
        s = ecnt + 1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (tx_busy !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", 32'(n < 3000), 32'(1));
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_ecnt(input int target);
        int n;
        n = 0;
        while (ecnt != target && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("cycle_wait", 32'(ecnt), 32'(target));
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int slot);
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        return 1'b1;
    endfunction

    // Bad-cycle count for two contiguous frames starting at trace index s.
    function automatic int two_frame_bad(input int s, input logic [7:0] b0, input logic [7:0] b1);
        int bad;
        int slot;
        bad = 0;
        for (int j = 0; j < 2 * FRAME_CYC; j++) begin
            slot = j / CPB;
            if (txd_log[s+j] !== frame_bit((slot < 10) ? b0 : b1, slot % 10)) bad++;
        end
        return bad;
    endfunction

    initial begin
        int s, s1, s2, bad;
        int a5_bits[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

        // Reset, then 50 idle cycles
        repeat (3) @(negedge clk);
        rst = 1'b0;
        s = ecnt;
        repeat (50) @(negedge clk);
        bad = 0;
        for (int k = s + 1; k < s + 48; k++) begin
            if (txd_log[k] !== 1'b1 || rdy_log[k] !== 1'b1 || busy_log[k] !== 1'b0) bad++;
        end
        check("reset_idle_bad_cycles", 32'(bad), 32'(0));
        check("reset_txd", 32'(txd), 32'(1));
        check("reset_ready", 32'(tx_ready), 32'(1));
        check("reset_busy", 32'(tx_busy), 32'(0));

        // Single byte 0xA5
        rx_q.delete();
        send(8'hA5, s);
        tx_valid = 1'b0;
        wait_idle();
        bad = 0;
        for (int j = 0; j < FRAME_CYC; j++) begin
            if (txd_log[s+j] !== 1'(a5_bits[j/CPB])) bad++;
        end
        check("a5_frame_bad_cycles", 32'(bad), 32'(0));
        check("a5_line_before", 32'(txd_log[s-1]), 32'(1));
        check("a5_busy_last_stop", 32'(busy_log[s+39]), 32'(1));
        check("a5_busy_fall", 32'(busy_log[s+40]), 32'(0));
        check("a5_rx_count", 32'(rx_q.size()), 32'(1));
        if (rx_q.size() > 0) check("a5_rx_value", 32'(rx_q[0]), 32'h0A5);

        // Back-to-back 0x55 then 0x0F
        rx_q.delete();
        send(8'h55, s1);
        send(8'h0F, s2);
        tx_valid = 1'b0;
        wait_idle();
        check("b2b_second_accept", 32'(s2), 32'(s1 + 1));
        check("b2b_frames_bad_cycles", 32'(two_frame_bad(s1, 8'h55, 8'h0F)), 32'(0));
        check("b2b_ready_before_hold", 32'(rdy_log[s1]), 32'(1));
        bad = 0;
        for (int k = s1 + 1; k < s1 + 40; k++) if (rdy_log[k] !== 1'b0) bad++;
        check("b2b_ready_low_cycles_bad", 32'(bad), 32'(0));
        check("b2b_ready_rise", 32'(rdy_log[s1+40]), 32'(1));
        check("b2b_busy_last", 32'(busy_log[s1+79]), 32'(1));
        check("b2b_busy_fall", 32'(busy_log[s1+80]), 32'(0));
        check("b2b_rx_count", 32'(rx_q.size()), 32'(2));
        if (rx_q.size() > 1) begin
            check("b2b_rx_0", 32'(rx_q[0]), 32'h055);
            check("b2b_rx_1", 32'(rx_q[1]), 32'h00F);
        end

        // Bypass accept in the last stop-bit cycle
        rx_q.delete();
        send(8'hC3, s1);
        tx_valid = 1'b0;
        wait_ecnt(s1 + 39);
        send(8'h00, s2);
        tx_valid = 1'b0;
        wait_idle();
        check("bypass_start_index", 32'(s2), 32'(s1 + 40));
        check("bypass_frames_bad_cycles", 32'(two_frame_bad(s1, 8'hC3, 8'h00)), 32'(0));
        bad = 0;
        for (int k = s1; k <= s1 + 80; k++) if (rdy_log[k] !== 1'b1) bad++;
        check("bypass_ready_drop_cycles", 32'(bad), 32'(0));
        check("bypass_rx_count", 32'(rx_q.size()), 32'(2));

        // Reset during data bit 3 with a byte held
        rx_q.delete();
        send(8'h81, s1);
        send(8'h7E, s2);
        tx_valid = 1'b0;
        wait_ecnt(s1 + 17);
        check("midrst_held_before", 32'(tx_ready), 32'(0));
        rst = 1'b1;
        @(negedge clk);
        check("midrst_txd", 32'(txd), 32'(1));
        check("midrst_ready", 32'(tx_ready), 32'(1));
        check("midrst_busy", 32'(tx_busy), 32'(0));
        rst = 1'b0;
        repeat (60) @(negedge clk);
        bad = 0;
        for (int k = s1 + 18; k < s1 + 75; k++) if (txd_log[k] !== 1'b1) bad++;
        check("midrst_line_idle_bad", 32'(bad), 32'(0));
        check("midrst_rx_count", 32'(rx_q.size()), 32'(0));

        // Loopback sweep of all byte values, back-to-back
        rx_q.delete();
        for (int i = 0; i < 256; i++) send(8'(i), s);
        tx_valid = 1'b0;
        wait_idle();
        check("sweep_rx_count", 32'(rx_q.size()), 32'(256));
        for (int i = 0; i < 256 && i < rx_q.size(); i++) begin
            check("sweep_byte", 32'(rx_q[i]), 32'(i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Byte-wide UART transmitter driving `ftdi_txd` in the SOC, replacing the constant-0 tie-off on the transmit pin. The CPU side presents bytes through a valid/ready handshake. A one-entry holding register lets the next byte be accepted while the current frame shifts out. Frame format is fixed 8N1, LSB first, with an idle-high line.

## Interface
- `CLK_FREQ_HZ`, default 25_000_000: frequency of `clk` in Hz.
- `BAUD_RATE`, default 115200: line rate in bit/s.
- Derived constant `CLKS_PER_BIT` = `CLK_FREQ_HZ / BAUD_RATE`, using integer truncation (217 at the defaults).
  - Elaboration must fail if `CLKS_PER_BIT < 2`.
- `clk` in 1: system clock. One clock domain only.
- `rst` in 1: reset, synchronous and active-high.
- `tx_valid` in 1: `tx_data` holds a byte to send.
- `tx_data` in 8: byte to transmit. Sampled only on acceptance.
- `tx_ready` out 1: a byte can be accepted this cycle.
- `tx_busy` out 1: a frame is shifting or a byte is held.
- `txd` out 1: serial line, connected to `ftdi_txd`.

## Operation
- Acceptance happens on a rising edge where `tx_valid && tx_ready`.
- `tx_ready` is combinational: `tx_ready = !hold_full`. It does not depend on `tx_valid`.
- Where an accepted byte goes:
  - Shifter idle, or in the last cycle of its stop bit: the byte goes straight into the shifter (bypass) and `hold_full` stays 0.
  - Otherwise: the byte goes into the holding register and `hold_full` becomes 1.
- Shifter FSM states are IDLE, START, DATA and STOP.
  - IDLE → START on load. Load comes from a bypassed byte or from the holding register.
  - START → DATA after `CLKS_PER_BIT` cycles.
  - DATA → STOP after 8 bits of `CLKS_PER_BIT` cycles each. Bit index runs 0..7, LSB first.
  - STOP → START if `hold_full` or a bypass accept occurs in the last STOP cycle. Otherwise STOP → IDLE.
  - On STOP → START from the holding register, `hold_full` clears in the same edge.
- `txd` per state: IDLE=1, START=0, DATA=`shift[0]`, STOP=1.
- `txd` is registered and glitch-free.
- Counters:
  - Baud counter is `$clog2(CLKS_PER_BIT)` bits wide and counts 0..`CLKS_PER_BIT-1`. It resets to 0 on every bit boundary.
  - Bit counter is 3 bits and wraps 7→0 on DATA exit.
- `tx_busy = (state != IDLE) || hold_full`.
- A `tx_valid` held high while `tx_ready` is low is ignored. The bench, not this block, checks that `tx_data` stays stable.
- When `rst` is asserted mid-frame:
  - Next edge: `txd`=1, state=IDLE, `hold_full`=0, both counters 0.
  - Any held byte is discarded and the truncated frame is not resumed.

## Timing
- Reset values: `txd`=1, `tx_ready`=1, `tx_busy`=0.
- Start latency: an accept at edge N with the shifter idle drives `txd` low for the cycle after edge N. No dead cycle.
- Frame length: exactly `10*CLKS_PER_BIT` cycles. Each bit, including the stop bit, lasts exactly `CLKS_PER_BIT` cycles.
- Back-to-back frames: when the next byte is held or bypassed in the last STOP cycle, its start bit immediately follows the stop bit. No idle gap.
- Throughput with `tx_valid` held high:
  - `tx_ready` drops one cycle after the second accept.
  - It rises again in the cycle after the first frame's last STOP cycle.
- `tx_busy` falls in the cycle after the last STOP cycle, and only when nothing is pending.

## Structure
- Shared header `uart_defs.vh`, also intended for the later receiver:
  - state encodings `UART_IDLE`/`UART_START`/`UART_DATA`/`UART_STOP`, 2 bits;
  - the `CLKS_PER_BIT` computation macro;
  - the frame-length constant 10.
- One natural sub-module, `uart_baud_tick`: the parameterised bit-period counter.
  - Ports: `clk`, `rst`, `restart`, `tick`.
  - It pulses `tick` in the last cycle of each bit period.
- FSM, shifter and holding register stay in `uart_tx`.

## Test plan
Bench parameters: `CLK_FREQ_HZ`=1_000_000, `BAUD_RATE`=250_000, giving `CLKS_PER_BIT`=4.

- **Reset:** hold `rst` 3 cycles, then release → `txd`=1, `tx_ready`=1, `tx_busy`=0 throughout, with no spurious start bit over 50 idle cycles.
- **Single byte:** accept 0xA5 at edge N → over 40 cycles from N+1, `txd` shows 0, 1,0,1,0,0,1,0,1, 1, each bit 4 cycles wide. `tx_busy` falls at N+41.
- **Back-to-back:** `tx_valid`=1 with 0x55 then 0x0F → second byte held, `tx_ready`=0 until frame 1 ends. The frame 2 start bit begins at cycle 41 with no gap, and 80 contiguous frame cycles are observed.
- **Bypass on last STOP cycle:** accept 0x00 exactly in the 4th stop-bit cycle of a frame → next start bit begins the following cycle and `hold_full` never asserts.
- **Mid-frame reset:** assert `rst` during the DATA bit-3 period with a byte held → next cycle `txd`=1, `tx_ready`=1, `tx_busy`=0. The held byte is never transmitted.
- **Sweep:** loopback a behavioural UART receiver model on `txd` and send all 256 byte values back-to-back → all values recovered in order with no framing errors.
